// File: rtl/and_reduce_seq.sv
// and_reduce_seq: time-shared wide AND reduction, one CHUNK-bit slice per clock
// and_cascade : a (LENGTH bits) in, y = AND of all bits out
// and_reduce_seq ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake, in_data sampled on acceptance
//   out_valid/out_ready  result handshake
//   out_result           AND of all evaluated bits
//   out_cycles           number of chunks evaluated (1..NCHUNK)
//   busy                 engine not idle
module and_cascade #(
  parameter int LENGTH = 8
) (
  input  logic [LENGTH-1:0] a,
  output logic              y
);
  assign y = &a;
endmodule

module and_reduce_seq #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int NCHUNK    = WIDTH / CHUNK,
  localparam int CW        = $clog2(NCHUNK) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [CW-1:0]    out_cycles,
  output logic             busy
);
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             acc;
  logic [WIDTH-1:0] op;
  logic [CHUNK-1:0] slice;
  logic             c;
  logic             stop;
  assign slice = op[idx*CHUNK +: CHUNK];
  and_cascade #(.LENGTH(CHUNK)) u_cascade (.a(slice), .y(c));
  // the final chunk always ends the pass; a zero chunk ends it early when enabled
  assign stop      = (idx == IW'(NCHUNK - 1)) || (EARLY_EXIT && !c);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= 1'b1;
      op         <= '0;
      out_result <= 1'b0;
      out_cycles <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        op    <= in_data;
        idx   <= '0;
        acc   <= 1'b1;
        state <= RUN;
      end
    end else if (state == RUN) begin
      acc <= acc & c;
      if (stop) begin
        out_result <= acc & c;
        out_cycles <= CW'(idx) + CW'(1);
        state      <= DONE;
      end else begin
        idx <= idx + IW'(1);
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_and_reduce_seq.sv
// tb_and_reduce_seq: random and directed checks of both early-exit settings against a chunk model
module tb_and_reduce_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        rdy1, val1, res1, busy1;
  logic        rdy0, val0, res0, busy0;
  logic [2:0]  cyc1, cyc0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  and_reduce_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(val1), .out_ready(out_ready), .out_result(res1), .out_cycles(cyc1), .busy(busy1)
  );
  and_reduce_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(val0), .out_ready(out_ready), .out_result(res0), .out_cycles(cyc0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // chunks evaluated: stop at the first chunk that is not all ones when early exit is on
  function automatic int exp_cycles(input logic [31:0] d, input bit ee);
    for (int k = 0; k < 4; k++)
      if (ee && d[k*8 +: 8] != 8'hFF) return k + 1;
    return 4;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_rdy"}, rdy1, 1);
    check({tag, "_val"}, val1, 0);
    check({tag, "_res"}, res1, 0);
    check({tag, "_cyc"}, cyc1, 0);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_rdy0"}, rdy0, 1);
    check({tag, "_val0"}, val0, 0);
  endtask

  task automatic accept(input logic [31:0] d);
    check("acc_rdy", rdy1 & rdy0, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // cycle-by-cycle expectations after acceptance with out_ready high
  task automatic check_after(input logic [31:0] d);
    int c1 = exp_cycles(d, 1'b1);
    int c0 = exp_cycles(d, 1'b0);
    logic r = &d;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      check("val1", val1, n == c1);
      check("rdy1", rdy1, n > c1);
      check("busy1", busy1, n <= c1);
      check("val0", val0, n == c0);
      check("rdy0", rdy0, n > c0);
      if (n == c1) begin
        check("res1", res1, r);
        check("cyc1", cyc1, c1);
      end
      if (n == c0) begin
        check("res0", res0, r);
        check("cyc0", cyc0, c0);
      end
    end
  endtask

  task automatic run_op(input logic [31:0] d);
    accept(d);
    check_after(d);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] d;
    for (int k = 0; k < 4; k++)
      d[k*8 +: 8] = ($urandom_range(3) != 0) ? 8'hFF : 8'($urandom);
    return d;
  endfunction

  initial begin
    logic [31:0] x;
    #2;
    check_reset("rst");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'hFFFF_FFFF);
    run_op(32'hFFFF_FEFF);
    run_op(32'hFFFF_FF00);
    run_op(32'h00FF_FFFF);
    run_op(32'h0000_0000);
    for (int i = 0; i < 40; i++) run_op(rand_operand());
    // backpressure: result held, new operand refused until the output handshake
    out_ready = 1'b0;
    accept(32'hFFFF_FFFF);
    repeat (4) @(posedge clk);
    #1;
    x = $urandom;
    in_valid = 1'b1;
    in_data  = x;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check("bp_val", val1, 1);
      check("bp_res", res1, 1);
      check("bp_cyc", cyc1, 4);
      check("bp_rdy", rdy1, 0);
      check("bp_busy", busy1, 1);
      check("bp_val0", val0, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_val", val1, 0);
    check("bp_rel_rdy", rdy1, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    check_after(x);
    // asynchronous reset mid-run at chunk index 2
    accept(32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("arst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset("arst_post");
    run_op(32'hFFFF_FFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
